// File: rtl/mio_bus_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory/MIO port between two requesters.
// Optional per-requester grant counters are enabled by defining MIO_ARB_CNT_EN.
module mio_bus_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter bit RST_PRIO    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
`ifdef MIO_ARB_CNT_EN
  output logic [15:0] m0_grants,
  output logic [15:0] m1_grants,
`endif
  output logic        grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_s;
  logic        prio_r;
  logic        prio_s;
  logic        winner_s;
  logic        any_req_s;
  logic        last_s;

  logic        mem_en_s;
  logic        mem_we_s;
  logic [31:0] mem_addr_s;
  logic [31:0] mem_wdata_s;
  logic [31:0] m0_rdata_s;
  logic [31:0] m1_rdata_s;
  logic        m0_ready_s;
  logic        m1_ready_s;
  logic        busy_s;
  logic        grant_s;

  assign any_req_s = m0_req | m1_req;
  assign last_s    = (cnt_r == LAST_CNT);

  // Winner selection: a lone requester wins, a tie goes to the round-robin pointer.
  always_comb begin
    winner_s = 1'b0;
    if (m0_req && m1_req) begin
      winner_s = prio_r;
    end else if (m1_req) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = ACCESS;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of every registered output; ready defaults low so it is a single-cycle pulse.
  always_comb begin
    mem_en_s    = mem_en;
    mem_we_s    = mem_we;
    mem_addr_s  = mem_addr;
    mem_wdata_s = mem_wdata;
    m0_rdata_s  = m0_rdata;
    m1_rdata_s  = m1_rdata;
    m0_ready_s  = 1'b0;
    m1_ready_s  = 1'b0;
    grant_s     = grant;
    prio_s      = prio_r;
    cnt_s       = cnt_r;
    busy_s      = (state_s != IDLE);
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          mem_en_s    = 1'b1;
          mem_we_s    = winner_s ? m1_we    : m0_we;
          mem_addr_s  = winner_s ? m1_addr  : m0_addr;
          mem_wdata_s = winner_s ? m1_wdata : m0_wdata;
          grant_s     = winner_s;
          prio_s      = ~winner_s;
          cnt_s       = 4'd0;
        end else begin
          mem_en_s = 1'b0;
          cnt_s    = 4'd0;
        end
      end
      ACCESS: begin
        cnt_s = cnt_r + 4'd1;
        if (last_s) begin
          if (!mem_we) begin
            if (grant) begin
              m1_rdata_s = mem_rdata;
            end else begin
              m0_rdata_s = mem_rdata;
            end
          end else begin
            m0_rdata_s = m0_rdata;
          end
          if (grant) begin
            m1_ready_s = 1'b1;
          end else begin
            m0_ready_s = 1'b1;
          end
          mem_en_s = 1'b0;
          mem_we_s = 1'b0;
        end else begin
          mem_en_s = 1'b1;
        end
      end
      DONE: begin
        mem_en_s = 1'b0;
        cnt_s    = 4'd0;
      end
      default: begin
        mem_en_s = 1'b0;
        mem_we_s = 1'b0;
        cnt_s    = 4'd0;
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= 4'd0;
      prio_r    <= RST_PRIO;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      m0_rdata  <= 32'd0;
      m1_rdata  <= 32'd0;
      m0_ready  <= 1'b0;
      m1_ready  <= 1'b0;
      busy      <= 1'b0;
      grant     <= RST_PRIO;
    end else begin
      cnt_r     <= cnt_s;
      prio_r    <= prio_s;
      mem_en    <= mem_en_s;
      mem_we    <= mem_we_s;
      mem_addr  <= mem_addr_s;
      mem_wdata <= mem_wdata_s;
      m0_rdata  <= m0_rdata_s;
      m1_rdata  <= m1_rdata_s;
      m0_ready  <= m0_ready_s;
      m1_ready  <= m1_ready_s;
      busy      <= busy_s;
      grant     <= grant_s;
    end
  end

`ifdef MIO_ARB_CNT_EN
  logic take_s;
  assign take_s = (state_r == IDLE) && any_req_s;

  // Saturating grant counters, bumped on the IDLE->ACCESS edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_grants <= 16'd0;
      m1_grants <= 16'd0;
    end else begin
      if (take_s && !winner_s && (m0_grants != 16'hFFFF)) begin
        m0_grants <= m0_grants + 16'd1;
      end
      if (take_s && winner_s && (m1_grants != 16'hFFFF)) begin
        m1_grants <= m1_grants + 16'd1;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed self-checking bench: MEM_LATENCY=2 instance for the main scenarios,
// MEM_LATENCY=1 instance for the back-to-back single-master case.
module tb_mio_bus_arbiter;

  logic        clk;
  logic        rst;
  int          pass_cnt;
  int          total_cnt;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        mem_en, mem_we, busy, grant;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        l_m0_req, l_m0_we, l_m1_req, l_m1_we;
  logic [31:0] l_m0_addr, l_m0_wdata, l_m1_addr, l_m1_wdata;
  logic [31:0] l_m0_rdata, l_m1_rdata;
  logic        l_m0_ready, l_m1_ready;
  logic        l_mem_en, l_mem_we, l_busy, l_grant;
  logic [31:0] l_mem_addr, l_mem_wdata, l_mem_rdata;

`ifdef MIO_ARB_CNT_EN
  logic [15:0] m0_grants, m1_grants, l_m0_grants, l_m1_grants;
`endif

  // Memory models: fixed pattern per address.
  assign mem_rdata   = (mem_addr == 32'h0000_0010) ? 32'hDEAD_BEEF : {mem_addr[15:0], 16'hC0DE};
  assign l_mem_rdata = l_mem_addr ^ 32'hFFFF_0000;

  mio_bus_arbiter #(.MEM_LATENCY(2), .RST_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy),
`ifdef MIO_ARB_CNT_EN
    .m0_grants(m0_grants), .m1_grants(m1_grants),
`endif
    .grant(grant)
  );

  mio_bus_arbiter #(.MEM_LATENCY(1), .RST_PRIO(1'b0)) dut1 (
    .clk(clk), .rst(rst),
    .m0_req(l_m0_req), .m0_we(l_m0_we), .m0_addr(l_m0_addr), .m0_wdata(l_m0_wdata),
    .m0_rdata(l_m0_rdata), .m0_ready(l_m0_ready),
    .m1_req(l_m1_req), .m1_we(l_m1_we), .m1_addr(l_m1_addr), .m1_wdata(l_m1_wdata),
    .m1_rdata(l_m1_rdata), .m1_ready(l_m1_ready),
    .mem_en(l_mem_en), .mem_we(l_mem_we), .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata),
    .mem_rdata(l_mem_rdata), .busy(l_busy),
`ifdef MIO_ARB_CNT_EN
    .m0_grants(l_m0_grants), .m1_grants(l_m1_grants),
`endif
    .grant(l_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++;
    if ({mem_en, mem_we, busy, grant, m0_ready, m1_ready} !== 6'b000000)
      $display("FAIL reset_ctrl: got %b want 000000", {mem_en, mem_we, busy, grant, m0_ready, m1_ready});
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr, mem_wdata, m0_rdata, m1_rdata} !== 128'd0)
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, m0_rdata, m1_rdata});
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
    @(negedge clk);
    total_cnt++;
    if ({mem_en, mem_we, busy, grant} !== 4'b1010)
      $display("FAIL rd_c1_ctrl: got %b want 1010", {mem_en, mem_we, busy, grant});
    else pass_cnt++;
    total_cnt++;
    if (mem_addr !== 32'h0000_0010) $display("FAIL rd_addr: got %h want 00000010", mem_addr);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({mem_en, m0_ready} !== 2'b10) $display("FAIL rd_c2: got %b want 10", {mem_en, m0_ready});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({mem_en, m0_ready, m1_ready} !== 3'b010)
      $display("FAIL rd_c3_ready: got %b want 010", {mem_en, m0_ready, m1_ready});
    else pass_cnt++;
    total_cnt++;
    if (m0_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h want deadbeef", m0_rdata);
    else pass_cnt++;
    m0_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({m0_ready, busy} !== 2'b00) $display("FAIL rd_c4_idle: got %b want 00", {m0_ready, busy});
    else pass_cnt++;
  endtask

  task automatic test_write_m1();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0020; m1_wdata = 32'h1234_5678;
    @(negedge clk);
    total_cnt++;
    if ({mem_en, mem_we, grant} !== 3'b111 || mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h0000_0020)
      $display("FAIL wr_c1: got ctl=%b wdata=%h addr=%h want 111 12345678 00000020",
               {mem_en, mem_we, grant}, mem_wdata, mem_addr);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({mem_en, mem_we} !== 2'b11 || mem_wdata !== 32'h1234_5678)
      $display("FAIL wr_c2: got ctl=%b wdata=%h want 11 12345678", {mem_en, mem_we}, mem_wdata);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({m1_ready, m0_ready, mem_en, mem_we} !== 4'b1000)
      $display("FAIL wr_ready: got %b want 1000", {m1_ready, m0_ready, mem_en, mem_we});
    else pass_cnt++;
    total_cnt++;
    if (m1_rdata !== 32'd0 || m0_rdata !== 32'hDEAD_BEEF)
      $display("FAIL wr_rdata_hold: got m1=%h m0=%h want 0 deadbeef", m1_rdata, m0_rdata);
    else pass_cnt++;
    m1_req = 1'b0; m1_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_rdy;
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0040;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      exp_rdy = {(i == 7 || i == 15), (i == 3 || i == 11)};
      total_cnt++;
      if ({m1_ready, m0_ready} !== exp_rdy)
        $display("FAIL rr_ready_c%0d: got %b want %b", i, {m1_ready, m0_ready}, exp_rdy);
      else pass_cnt++;
      if (i == 5) begin
        total_cnt++;
        if (grant !== 1'b1) $display("FAIL rr_grant_m1: got %b want 1", grant);
        else pass_cnt++;
      end
      if (i == 7) begin
        total_cnt++;
        if (m1_rdata !== 32'h0040_C0DE) $display("FAIL rr_m1_rdata: got %h want 0040c0de", m1_rdata);
        else pass_cnt++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0050;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (mem_en !== 1'b1) $display("FAIL rst_mid_pre: got %b want 1", mem_en);
    else pass_cnt++;
    rst = 1'b1;
    m0_req = 1'b0;
    #1;
    total_cnt++;
    if ({mem_en, busy} !== 2'b00) $display("FAIL rst_mid_drop: got %b want 00", {mem_en, busy});
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({m0_ready, m1_ready} !== 2'b00) $display("FAIL rst_mid_noready: got %b want 00", {m0_ready, m1_ready});
      else pass_cnt++;
    end
    rst = 1'b0;
    m0_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'h0050_C0DE)
      $display("FAIL rst_mid_after: got rdy=%b data=%h want 1 0050c0de", m0_ready, m0_rdata);
    else pass_cnt++;
    m0_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back_lat1();
    logic [1:0] exp_v;
    l_m0_req = 1'b1; l_m0_we = 1'b0; l_m0_addr = 32'h0000_0008;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      exp_v = {(i == 1 || i == 4 || i == 7), (i == 2 || i == 5 || i == 8)};
      total_cnt++;
      if ({l_mem_en, l_m0_ready} !== exp_v)
        $display("FAIL lat1_c%0d: got en/rdy=%b want %b", i, {l_mem_en, l_m0_ready}, exp_v);
      else pass_cnt++;
      if (i == 2) begin
        total_cnt++;
        if (l_m0_rdata !== 32'hFFFF_0008) $display("FAIL lat1_rdata: got %h want ffff0008", l_m0_rdata);
        else pass_cnt++;
      end
    end
    l_m0_req = 1'b0;
    @(negedge clk);
  endtask

`ifdef MIO_ARB_CNT_EN
  task automatic test_grant_counters();
    do_reset();
    total_cnt++;
    if ({m0_grants, m1_grants} !== 32'd0) $display("FAIL cnt_reset: got %h want 0", {m0_grants, m1_grants});
    else pass_cnt++;
    m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
    repeat (16) @(negedge clk);
    m1_req = 1'b0;
    repeat (4) @(negedge clk);
    m0_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (m0_grants !== 16'd3 || m1_grants !== 16'd2)
      $display("FAIL cnt_values: got m0=%0d m1=%0d want 3 2", m0_grants, m1_grants);
    else pass_cnt++;
    do_reset();
    total_cnt++;
    if ({m0_grants, m1_grants} !== 32'd0) $display("FAIL cnt_reset2: got %h want 0", {m0_grants, m1_grants});
    else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
    l_m0_req = 1'b0; l_m0_we = 1'b0; l_m0_addr = 32'd0; l_m0_wdata = 32'd0;
    l_m1_req = 1'b0; l_m1_we = 1'b0; l_m1_addr = 32'd0; l_m1_wdata = 32'd0;
    test_reset();
    test_single_read();
    test_write_m1();
    test_simultaneous();
    test_reset_mid_access();
    test_back_to_back_lat1();
`ifdef MIO_ARB_CNT_EN
    test_grant_counters();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
- Shares one single-port data memory / MIO bus between two requesters.
- Requester 0 is the CPU data port (load/store address and data). Requester 1 is a secondary master, such as a debug loader or DMA.
- Runs a fixed-latency access sequence to the memory and returns a per-requester one-cycle ready pulse. The CPU core uses this pulse as its MIO_ready stall input.
- Arbitration is round-robin, so neither master can starve the other.

Parameters:
- MEM_LATENCY, 2, memory cycles per access with mem_en held high; legal range 1..15.
- RST_PRIO, 0, requester that wins the first simultaneous request after reset (0 or 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  requester 0 access request; held until m0_ready.
- m0_we  in  1  requester 0 write (1) / read (0).
- m0_addr  in  32  requester 0 byte address.
- m0_wdata  in  32  requester 0 write data.
- m0_rdata  out  32  requester 0 read data; valid while m0_ready=1.
- m0_ready  out  1  requester 0 access-complete pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ready: same as m0_*, for requester 1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; only meaningful with mem_en.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid at the last mem_en cycle.
- busy  out  1  high in any state other than IDLE.
- grant  out  1  index of the current/last granted requester.

Behaviour:
- Reset values (async, applied immediately):
  - state=IDLE, counter=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - m0_ready=0, m1_ready=0, m0_rdata=0, m1_rdata=0.
  - busy=0, grant=RST_PRIO, round-robin pointer favours RST_PRIO.
- FSM states are IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If any req is high at a clock edge, select a winner. With one request, that requester wins. With both, the requester not granted last time wins.
  - At the same edge: latch the winner's addr/we/wdata into mem_addr/mem_we/mem_wdata, set mem_en=1, grant=winner, counter=0, and move to ACCESS.
- ACCESS:
  - mem_en stays high for exactly MEM_LATENCY cycles; counter increments each edge.
  - At the edge where counter==MEM_LATENCY-1:
    - capture mem_rdata into the winner's rdata register, only if mem_we=0;
    - clear mem_en and mem_we;
    - pulse the winner's ready to 1;
    - move to DONE.
- DONE:
  - Ready is high for exactly this one cycle; the next edge clears it and returns to IDLE.
  - A new request is not sampled in DONE. The earliest new grant is the edge leaving IDLE.
- Latency: if req is sampled at edge N, mem_en is high during cycles N..N+MEM_LATENCY-1 and ready is high in the cycle after edge N+MEM_LATENCY. Back-to-back accesses from the same master occur every MEM_LATENCY+2 cycles.
- Writes leave the rdata register unchanged.
- The non-granted rdata and ready never change.
- Requester protocol:
  - Requesters must hold req, addr, we and wdata stable until their ready.
  - The arbiter latches at grant, so later changes are ignored for the current access.
- Req dropped mid-access: the access still completes and the ready pulse is still issued.
- Req still high after ready: treated as a new request in IDLE, at the earliest the cycle after DONE. Round-robin then gives the other master priority if both are requesting.
- Reset mid-ACCESS: mem_en drops immediately, no ready is issued, and the access is abandoned.
- The counter width is sized for 15 and never wraps within a legal configuration.

Optional Feature:
- Macro: MIO_ARB_CNT_EN.
- When defined:
  - Adds output ports m0_grants [15:0] and m1_grants [15:0].
  - Each counter increments by 1 at the IDLE->ACCESS edge for that master, saturating at 16'hFFFF.
  - Both counters are 0 on reset.
- When undefined: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Single read, MEM_LATENCY=2:
  - Stimulus: m0_req=1, m0_we=0, m0_addr=32'h0000_0010, memory returns 32'hDEAD_BEEF.
  - Required: mem_en high for 2 cycles with mem_addr=32'h10; m0_ready pulses for 1 cycle, 3 cycles after grant, with m0_rdata=32'hDEAD_BEEF; m1_ready stays 0.
- Write from requester 1:
  - Stimulus: m1_we=1, m1_addr=32'h20, m1_wdata=32'h1234_5678.
  - Required: mem_we=1 and mem_wdata=32'h1234_5678 for both mem_en cycles; m1_ready pulses; m1_rdata unchanged.
- Simultaneous requests after reset, RST_PRIO=0, both req held:
  - Required: grants alternate m0, m1, m0, m1, with each ready pulse 4 cycles apart.
- Async reset asserted in the 2nd ACCESS cycle:
  - Required: mem_en=0 and busy=0 immediately, no ready pulse; after release, a new m0 request completes normally.
- MEM_LATENCY=1, m0 holds req continuously:
  - Required: m0_ready pulses every 3 cycles, and mem_en is never high in DONE.
- With MIO_ARB_CNT_EN defined:
  - Stimulus: 3 m0 accesses and 2 m1 accesses.
  - Required: m0_grants=3, m1_grants=2; after reset, both read 0.
